// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, divisor floor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int MIN_CLKS_PER_BIT = 2;

  // data_xor is the XOR of every data bit of the frame.
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    case (mode)
      PAR_ODD:  return ~data_xor;
      PAR_EVEN: return data_xor;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: latches a divisor on load (floored at MIN_CLKS_PER_BIT),
// counts 0..N-1 while enabled and pulses o_bit_end on the last count.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_en,
  output logic             o_bit_end
);

  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(MIN_CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign o_bit_end = i_en && (cnt_q == div_q - ONE);

  // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (i_load) begin
      div_d = (i_div < MIN_DIV) ? MIN_DIV : i_div;
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_bit_end ? '0 : cnt_q + ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      div_q <= MIN_DIV;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-word holding buffer so frames can
// run back-to-back; divisor, parity and stop bits are latched per frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic [DIV_W-1:0]  i_Clks_Per_Bit,
  input  logic [1:0]        i_Parity_Mode,
  input  logic              i_Two_Stop,
  input  logic              i_Tx_Valid,
  input  logic [DATA_W-1:0] i_Tx_Data,
  output logic              o_Tx_Ready,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Active,
  output logic              o_Tx_Done
);

  localparam int              IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  tx_state_e          state_q, state_d;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               stop_idx_q, stop_idx_d;
  logic [1:0]         par_mode_q, par_mode_d;
  logic               two_stop_q, two_stop_d;
  logic               par_bit_q, par_bit_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               load;
  logic               bit_end;

  uart_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_load    (load),
    .i_div     (i_Clks_Per_Bit),
    .i_en      (state_q != IDLE),
    .o_bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_mode_d = par_mode_q;
    two_stop_d = two_stop_q;
    par_bit_d  = par_bit_q;
    done_d     = 1'b0;
    load       = 1'b0;

    // A write and a load never coincide: writes need an empty buffer, loads a full one.
    if (i_Tx_Valid && !buf_full_q) begin
      buf_d      = i_Tx_Data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE:   load = buf_full_q;
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = (par_mode_q != PAR_NONE) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            stop_idx_d = 1'b0;
            done_d     = 1'b1;
            if (buf_full_q) load = 1'b1;
            else            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      par_mode_d = i_Parity_Mode;
      two_stop_d = i_Two_Stop;
      par_bit_d  = parity_bit(i_Parity_Mode, ^buf_q);
      state_d    = START;
    end

    // The line is registered from the next state so the pin never glitches.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = par_bit_d;
      default: serial_d = 1'b1;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_mode_q <= PAR_NONE;
      two_stop_q <= 1'b0;
      par_bit_q  <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_mode_q <= par_mode_d;
      two_stop_q <= two_stop_d;
      par_bit_q  <= par_bit_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign o_Tx_Ready  = !buf_full_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: 8-, 5- and 9-bit instances share config; a scoreboard
// of expected per-cycle line waveforms is checked by a single frame monitor.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] div;
  logic [1:0]  pmode;
  logic        two;
  logic        tx_valid;
  logic [8:0]  tx_data;
  int          sel;
  int          width_now;

  logic v8, v5, v9;
  logic r8, s8, a8, d8, r5, s5, a5, d5, r9, s9, a9, d9;
  logic mon_serial, mon_active, mon_done, mon_ready;

  assign v8 = tx_valid && (sel == 0);
  assign v5 = tx_valid && (sel == 1);
  assign v9 = tx_valid && (sel == 2);
  assign mon_serial = (sel == 1) ? s5 : (sel == 2) ? s9 : s8;
  assign mon_active = (sel == 1) ? a5 : (sel == 2) ? a9 : a8;
  assign mon_done   = (sel == 1) ? d5 : (sel == 2) ? d9 : d8;
  assign mon_ready  = (sel == 1) ? r5 : (sel == 2) ? r9 : r8;

  uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) dut8 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div), .i_Parity_Mode(pmode),
    .i_Two_Stop(two), .i_Tx_Valid(v8), .i_Tx_Data(tx_data[7:0]), .o_Tx_Ready(r8),
    .o_Tx_Serial(s8), .o_Tx_Active(a8), .o_Tx_Done(d8));
  uart_tx_cfg #(.DATA_W(5), .DIV_W(16)) dut5 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div), .i_Parity_Mode(pmode),
    .i_Two_Stop(two), .i_Tx_Valid(v5), .i_Tx_Data(tx_data[4:0]), .o_Tx_Ready(r5),
    .o_Tx_Serial(s5), .o_Tx_Active(a5), .o_Tx_Done(d5));
  uart_tx_cfg #(.DATA_W(9), .DIV_W(16)) dut9 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div), .i_Parity_Mode(pmode),
    .i_Two_Stop(two), .i_Tx_Valid(v9), .i_Tx_Data(tx_data), .o_Tx_Ready(r9),
    .o_Tx_Serial(s9), .o_Tx_Active(a9), .o_Tx_Done(d9));

  typedef struct {
    logic [127:0] wave;
    int           len;
    bit           b2b;
  } exp_t;

  exp_t q[$];
  int   starts[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mon_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Independent frame model: expected line level for every cycle of one frame.
  function automatic exp_t make_exp(input logic [8:0] d, input int width, input int n_in,
                                    input logic [1:0] mode, input logic two_s, input bit b2b);
    exp_t       e;
    logic [12:0] bv;
    int         nb;
    int         n;
    logic       x;
    n = (n_in < 2) ? 2 : n_in;
    bv = '0;
    bv[0] = 1'b0;
    nb = 1;
    x = 1'b0;
    for (int i = 0; i < width; i++) begin
      bv[nb] = d[i];
      nb = nb + 1;
      x = x ^ d[i];
    end
    if (mode != PAR_NONE) begin
      bv[nb] = (mode == PAR_EVEN) ? x : (mode == PAR_ODD) ? ~x : 1'b1;
      nb = nb + 1;
    end
    bv[nb] = 1'b1;
    nb = nb + 1;
    if (two_s) begin
      bv[nb] = 1'b1;
      nb = nb + 1;
    end
    e.wave = '0;
    e.len = 0;
    e.b2b = b2b;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < n; k++) begin
        e.wave[e.len] = bv[b];
        e.len = e.len + 1;
      end
    end
    return e;
  endfunction

  // Waits for ready, presents one word and returns right after the transfer edge.
  task automatic send(input logic [8:0] d, input bit b2b, input bit push);
    int w = 0;
    @(negedge clk);
    while (!mon_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!mon_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_ready: ready observed %b, required 1 within 1000 cycles", mon_ready);
      return;
    end
    tx_valid = 1'b1;
    tx_data  = d;
    if (push) q.push_back(make_exp(d, width_now, int'(div), pmode, two, b2b));
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Pops one expected frame per detected frame and compares it cycle by cycle.
  task automatic mon(input int nf);
    exp_t e;
    int   w, se, ae;
    @(negedge clk);
    for (int f = 0; f < nf; f++) begin
      w = 0;
      while (q.size() == 0 && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_empty: frame %0d had no expected entry", f);
        return;
      end
      e = q.pop_front();
      if (e.b2b) begin
        n_checks++;
        if (mon_serial !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_gap: line observed %b at done cycle, required 0 (start)", mon_serial);
        end
      end else begin
        while (mon_serial !== 1'b0 && w < 400) begin
          @(negedge clk);
          w++;
        end
        if (mon_serial !== 1'b0) begin
          n_checks++; n_fail++;
          $display("FAIL start_timeout: no start bit within 400 cycles, line %b", mon_serial);
          return;
        end
      end
      starts.push_back(cyc);
      se = 0;
      ae = 0;
      for (int i = 0; i < e.len; i++) begin
        if (mon_serial !== e.wave[i]) se++;
        if (mon_active !== 1'b1) ae++;
        @(negedge clk);
      end
      n_checks++;
      if (se != 0) begin
        n_fail++;
        $display("FAIL frame_wave: %0d of %0d cycles wrong, required 0", se, e.len);
      end
      n_checks++;
      if (ae != 0) begin
        n_fail++;
        $display("FAIL frame_active: active low in %0d cycles, required 0", ae);
      end
      n_checks++;
      if (mon_done !== 1'b1) begin
        n_fail++;
        $display("FAIL done_pulse: done observed %b after %0d cycles, required 1", mon_done, e.len);
      end
    end
  endtask

  task automatic check_done(input int d0, input int frames);
    @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != frames) begin
      n_fail++;
      $display("FAIL done_count: observed %0d pulses, required %0d", done_cnt - d0, frames);
    end
  endtask

  task automatic set_cfg(input int d, input logic [1:0] m, input logic t);
    @(negedge clk);
    div = 16'(d);
    pmode = m;
    two = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    div = 16'd4;
    pmode = PAR_NONE;
    two = 1'b0;
    sel = 0;
    width_now = 8;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s8, r8, a8, d8} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_state: {serial,ready,active,done} observed %b, required 1100",
               {s8, r8, a8, d8});
    end
    n_checks++;
    if ({s5, r5, s9, r9, a5, a9} !== 6'b111100) begin
      n_fail++;
      $display("FAIL reset_narrow_wide: {s5,r5,s9,r9,a5,a9} observed %b, required 111100",
               {s5, r5, s9, r9, a5, a9});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    set_cfg(4, PAR_NONE, 1'b0);
    fork
      begin send(9'h055, 0, 1); idle(); end
      mon(1);
    join
    check_done(d0, 1);
  endtask

  task automatic test_parity();
    logic [1:0] modes [3] = '{PAR_EVEN, PAR_ODD, PAR_MARK};
    logic [8:0] words [3] = '{9'h007, 9'h007, 9'h000};
    int d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      set_cfg(4, modes[i], 1'b0);
      fork
        begin send(words[i], 0, 1); idle(); end
        mon(1);
      join
    end
    check_done(d0, 3);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    set_cfg(4, PAR_EVEN, 1'b1);
    starts.delete();
    fork
      begin
        send(9'h0A5, 0, 1);
        send(9'h03C, 1, 1);
        send(9'h0FF, 1, 1);
        idle();
      end
      mon(3);
    join
    n_checks++;
    if (starts.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_starts: observed %0d start bits, required 3", starts.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (starts[i] - starts[i-1] != 48) begin
          n_fail++;
          $display("FAIL b2b_spacing: start %0d observed %0d cycles after previous, required 48",
                   i, starts[i] - starts[i-1]);
        end
      end
    end
    check_done(d0, 3);
  endtask

  task automatic test_min_div();
    int d0 = done_cnt;
    for (int dv = 0; dv < 2; dv++) begin
      set_cfg(dv, PAR_NONE, 1'b0);
      fork
        begin send(9'h096, 0, 1); idle(); end
        mon(1);
      join
    end
    check_done(d0, 2);
  endtask

  task automatic test_div_change();
    int d0 = done_cnt;
    set_cfg(4, PAR_NONE, 1'b0);
    fork
      begin
        send(9'h031, 0, 1);
        idle();
        repeat (10) @(negedge clk);
        div = 16'd8;
        send(9'h0CE, 1, 1);
        idle();
      end
      mon(2);
    join
    check_done(d0, 2);
  endtask

  task automatic test_widths();
    int d0;
    set_cfg(4, PAR_NONE, 1'b0);
    for (int s = 1; s < 3; s++) begin
      sel = s;
      width_now = (s == 1) ? 5 : 9;
      d0 = done_cnt;
      fork
        begin send((s == 1) ? 9'h01F : 9'h1FF, 0, 1); idle(); end
        mon(1);
      join
      check_done(d0, 1);
    end
    @(negedge clk);
    sel = 0;
    width_now = 8;
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    int bad;
    set_cfg(4, PAR_NONE, 1'b0);
    send(9'h0C3, 0, 0);
    send(9'h03A, 0, 0);
    idle();
    repeat (12) @(negedge clk);
    n_checks++;
    if (r8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_frame_buffer: ready observed %b before reset, required 0", r8);
    end
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s8, r8, a8} !== 3'b110) begin
      n_fail++;
      $display("FAIL abort_state: {serial,ready,active} observed %b, required 110", {s8, r8, a8});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s8 !== 1'b1 || a8 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_discard: line active in %0d cycles after release, required 0", bad);
    end
    check_done(d0, 0);
    d0 = done_cnt;
    fork
      begin send(9'h05A, 0, 1); idle(); end
      mon(1);
    join
    check_done(d0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_min_div();
    test_div_change();
    test_widths();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter: the next generation of the team's fixed 8N1 transmitter. It adds a configurable data width, a runtime baud divisor, runtime parity and stop-bit selection, and a valid/ready input handshake with a one-entry holding buffer, so frames go back-to-back with no idle gap. It sits between a byte source (FIFO, command engine) and the board TX pin.

## Interface
Parameters:
- DATA_W, 8: data bits per frame, legal 5..9.
- DIV_W, 16: width of the baud divisor input.

Ports:
- i_Clock  in  1  system clock; the only clock.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Clks_Per_Bit  in  DIV_W  clocks per bit period; values 0 and 1 are treated as 2.
- i_Parity_Mode  in  2  00 none, 01 odd, 10 even, 11 mark (parity bit = 1).
- i_Two_Stop  in  1  1 = two stop bits, 0 = one stop bit.
- i_Tx_Valid  in  1  source has a word on i_Tx_Data.
- i_Tx_Data  in  DATA_W  word to send, transmitted LSB first.
- o_Tx_Ready  out  1  holding buffer empty; transfer occurs on a rising edge where valid and ready are both high.
- o_Tx_Serial  out  1  serial line, idle high.
- o_Tx_Active  out  1  high while a frame is being shifted.
- o_Tx_Done  out  1  one-cycle pulse after each frame's final stop bit.

## Operation
- Holding buffer: written on valid&&ready; o_Tx_Ready = !buffer_full (registered flag). Cleared when the FSM loads it into the shifter. Full-buffer writes cannot occur because ready is low.
- Config (divisor, parity, stop bits) is sampled when the shifter loads and held for the whole frame. Changes mid-frame affect only the next frame.
- FSM states, all encoded in the shared package:
  - IDLE: drive 1. If the buffer is full: load the shifter, latch config, clear the buffer, go to START.
  - START: drive 0 for one bit period, then go to DATA.
  - DATA: drive shifter[0] and shift right each period. After DATA_W bits, go to PARITY if mode != 00, else STOP.
  - PARITY: drive one bit for one period. Even: XOR of the data. Odd: inverted XOR. Mark: 1. Then go to STOP.
  - STOP: drive 1 for one period, or two periods if i_Two_Stop was latched. On its last cycle:
    - if the buffer is full, load the next word and go directly to START;
    - else go to IDLE.
- Bit timer counts 0..N-1, where N = max(latched divisor, 2). It advances to the next bit on count N-1 and resets to 0.
- o_Tx_Active: high from START entry until leaving STOP to IDLE. It stays high across back-to-back frames.

## Timing
- Reset values: o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, buffer empty, FSM IDLE, counters 0.
- Reset asserted mid-frame aborts immediately: line high, buffer discarded, no Done pulse.
- Handshake at edge E with the FSM idle: o_Tx_Serial goes low after edge E+1, and o_Tx_Ready returns high after edge E+1.
- Every bit, including parity and stop bits, lasts exactly N cycles.
- Frame length = N*(1 + DATA_W + P + S) cycles, where P = 1 if parity is enabled (else 0) and S = 1 or 2.
- o_Tx_Done is high for the single cycle after the last stop cycle. The same edge starts the next start bit when back-to-back.
- Back-to-back: zero idle cycles between frames if the next word was accepted before the final stop cycle.
- A write accepted in the same cycle the buffer is loaded into the shifter is impossible: ready is low in that cycle.

## Structure
- Shared package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK;
  - MIN_CLKS_PER_BIT = 2.
- One sub-module, uart_bit_timer: DIV_W-wide counter with load/clear and a bit_end pulse. The receiver will reuse it later.
- Everything else (buffer, shifter, FSM, parity accumulator) stays in uart_tx_cfg.

## Test plan
- DATA_W=8, N=4, parity none, 1 stop, send 0x55 -> 40-cycle frame: line low 4, then 1,0,1,0,1,0,1,0 at 4 cycles each LSB first, high 4; Done pulses once; Active high for 40 cycles.
- Even parity, send 0x07 -> parity bit 1; odd parity, send 0x07 -> 0; mark, send 0x00 -> 1; frame 44 cycles at N=4.
- Two stop bits with three words held valid continuously (0xA5, 0x3C, 0xFF) -> frames contiguous with no idle cycle between them; start bits exactly 48 cycles apart at N=4; 3 Done pulses; Active never drops until the end.
- i_Clks_Per_Bit=0 and 1 -> each bit lasts 2 cycles. Divisor changed from 4 to 8 mid-frame -> current frame stays at 4, next frame uses 8.
- DATA_W=5 and DATA_W=9 instances, send the all-ones word -> exactly 5 or 9 data bits, correct frame length.
- Assert i_Rst_n low during the DATA state with the buffer full -> line high immediately, Ready=1, Active=0, no Done pulse. After release, the next write transmits normally.
